game_state_ctrl: RTL

Parametrised game-state controller replacing the separate score, fruits and lives registers and the ad-hoc win/lose wiring in the Pacman top level. It owns the round FSM, a BCD score, lives, the dots-remaining counter, the frightened-mode timer and the ghost combo multiplier. Its outputs are `restart` and `lifeDown` pulses to the pacman and ghost movers, and display-ready score digits for the HEX drivers and color mapper.

---
 rtl/game_pkg.sv | 41 ++++
 rtl/bcd_add.sv | 51 +++++
 rtl/game_state_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the Pacman game-state controller:
//   game_state_t   - round FSM states (also driven out of the controller)
//   bcd_digit_t    - one packed BCD digit
//   PTS_*          - point values awarded per event
//   to_bcd()       - elaboration-time conversion of an integer to packed BCD,
//                    used to build the score addend constants (max 8 digits)
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLAY     = 3'd1,
      ST_DYING    = 3'd2,
      ST_WIN      = 3'd3,
      ST_GAMEOVER = 3'd4
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int PTS_DOT        = 10;
   localparam int PTS_PELLET     = 50;
   localparam int PTS_GHOST_BASE = 200;

   localparam int BCD_MAX_DIGITS = 8;

   // Only ever called with constant arguments, so it folds away at elaboration.
   function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
      logic [4*BCD_MAX_DIGITS-1:0] result;
      int unsigned                 rest;
      result = '0;
      rest   = value;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         result[4*i +: 4] = 4'(rest % 10);
         rest             = rest / 10;
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_add.sv
// -----------------------------------------------------------------------------
// bcd_add
// Combinational packed-BCD adder with saturation. Adds i_b to i_a digit by
// digit with a ripple carry; if the top digit carries out the result clamps
// to all 9s instead of wrapping.
//   i_a   [4*DIGITS-1:0] : running value (valid BCD), digit 0 in LSBs
//   i_b   [4*DIGITS-1:0] : addend (valid BCD), digit 0 in LSBs
//   o_sum [4*DIGITS-1:0] : saturated BCD sum
// -----------------------------------------------------------------------------
module bcd_add
   import game_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] i_a,
   input  logic [4*DIGITS-1:0] i_b,
   output logic [4*DIGITS-1:0] o_sum
);

   bcd_digit_t w_a_dig;
   bcd_digit_t w_b_dig;
   logic [4:0] w_digit;
   logic       w_carry;

   // NOTE: every signal written in a combinational block gets a default on
   // entry; a path that leaves one unassigned would infer a latch.
   always_comb begin
      w_carry = 1'b0;
      w_a_dig = '0;
      w_b_dig = '0;
      w_digit = '0;
      o_sum   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_a_dig = i_a[4*i +: 4];
         w_b_dig = i_b[4*i +: 4];
         w_digit = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, w_carry};
         // Decimal correction: adding 6 skips the six unused nibble codes.
         if (w_digit > 5'd9) begin
            w_digit = w_digit + 5'd6;
            w_carry = 1'b1;
         end else begin
            w_carry = 1'b0;
         end
         o_sum[4*i +: 4] = w_digit[3:0];
      end
      if (w_carry) begin
         o_sum = {DIGITS{4'h9}};
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Pacman round controller: round FSM, BCD score, lives, dots remaining,
// frightened-mode timer and ghost combo multiplier. All outputs registered.
// Inputs : Clk, Reset_n (async, active-low), frame_tick (one pulse per frame),
//          start (level), dot_eaten / pellet_eaten / ghost_eaten / ghost_hit
//          (one-cycle pulses, honoured only in PLAY).
// Outputs: score_bcd (digit 0 in LSBs), lives, dots_left, state, frightened,
//          restart / lifeDown (one-cycle pulses on the first cycle of the new
//          state), win / lose (high while in WIN / GAMEOVER).
// -----------------------------------------------------------------------------
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int SCORE_DIGITS  = 4,   // 1..8
   parameter int LIVES_INIT    = 3,
   parameter int LIVES_W       = 4,
   parameter int DOT_COUNT     = 240,
   parameter int DOTS_W        = 9,
   parameter int FRIGHT_FRAMES = 360,
   parameter int DEATH_FRAMES  = 90
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      frame_tick,
   input  logic                      start,
   input  logic                      dot_eaten,
   input  logic                      pellet_eaten,
   input  logic                      ghost_eaten,
   input  logic                      ghost_hit,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic [LIVES_W-1:0]        lives,
   output logic [DOTS_W-1:0]         dots_left,
   output game_state_t               state,
   output logic                      frightened,
   output logic                      restart,
   output logic                      lifeDown,
   output logic                      win,
   output logic                      lose
);

   localparam int SW   = 4*SCORE_DIGITS;
   localparam int FR_W = $clog2(FRIGHT_FRAMES + 1);
   localparam int DT_W = $clog2(DEATH_FRAMES + 1);

   localparam logic [FR_W-1:0]    FRIGHT_LOAD = FR_W'(FRIGHT_FRAMES);
   localparam logic [DT_W-1:0]    DEATH_LAST  = DT_W'(DEATH_FRAMES - 1);
   localparam logic [DOTS_W-1:0]  DOTS_LOAD   = DOTS_W'(DOT_COUNT);
   localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);

   localparam logic [SW-1:0] BCD_DOT    = SW'(to_bcd(PTS_DOT));
   localparam logic [SW-1:0] BCD_PELLET = SW'(to_bcd(PTS_PELLET));
   localparam logic [SW-1:0] BCD_GHOST0 = SW'(to_bcd(PTS_GHOST_BASE));
   localparam logic [SW-1:0] BCD_GHOST1 = SW'(to_bcd(PTS_GHOST_BASE * 2));
   localparam logic [SW-1:0] BCD_GHOST2 = SW'(to_bcd(PTS_GHOST_BASE * 4));
   localparam logic [SW-1:0] BCD_GHOST3 = SW'(to_bcd(PTS_GHOST_BASE * 8));

   game_state_t         r_state;
   logic [SW-1:0]       r_score;
   logic [LIVES_W-1:0]  r_lives;
   logic [DOTS_W-1:0]   r_dots;
   logic [FR_W-1:0]     r_fright_cnt;
   logic [DT_W-1:0]     r_death_cnt;
   logic [1:0]          r_combo;
   logic                r_pend_dot, r_pend_pellet, r_pend_ghost;
   logic [1:0]          r_pend_combo;   // combo captured when a ghost was queued
   logic                r_frightened, r_restart, r_life_down, r_win, r_lose;

   game_state_t         w_state_nxt;
   logic [SW-1:0]       w_score_nxt, w_addend, w_sum;
   logic [LIVES_W-1:0]  w_lives_nxt;
   logic [DOTS_W-1:0]   w_dots_nxt;
   logic [FR_W-1:0]     w_fright_nxt;
   logic [DT_W-1:0]     w_death_nxt;
   logic [1:0]          w_combo_nxt, w_ghost_combo, w_pend_combo_nxt;
   logic                w_new_game, w_in_play, w_dot, w_pellet, w_ghost, w_death;
   logic                w_req_dot, w_req_pellet, w_req_ghost;
   logic                w_svc_dot, w_svc_pellet, w_svc_ghost;

   bcd_add #(.DIGITS(SCORE_DIGITS)) u_bcd_add (
      .i_a   (r_score),
      .i_b   (w_addend),
      .o_sum (w_sum)
   );

   always_comb begin
      w_in_play  = (r_state == ST_PLAY);
      w_new_game = ((r_state == ST_IDLE) || (r_state == ST_GAMEOVER)) && start;
      w_dot      = w_in_play && dot_eaten;
      w_pellet   = w_in_play && pellet_eaten;
      w_ghost    = w_in_play && ghost_eaten && r_frightened;
      w_death    = w_in_play && ghost_hit && !r_frightened;

      // Fresh pulses join the pending set so an uncontended event scores on
      // the very next edge; the winner is the highest-value request.
      w_req_dot     = r_pend_dot    || w_dot;
      w_req_pellet  = r_pend_pellet || w_pellet;
      w_req_ghost   = r_pend_ghost  || w_ghost;
      w_ghost_combo = r_pend_ghost ? r_pend_combo : r_combo;

      w_svc_dot    = 1'b0;
      w_svc_pellet = 1'b0;
      w_svc_ghost  = 1'b0;
      w_addend     = '0;
      if (w_req_ghost) begin
         w_svc_ghost = 1'b1;
         case (w_ghost_combo)
            2'd0: w_addend = BCD_GHOST0;
            2'd1: w_addend = BCD_GHOST1;
            2'd2: w_addend = BCD_GHOST2;
            2'd3: w_addend = BCD_GHOST3;
         endcase
      end else if (w_req_pellet) begin
         w_svc_pellet = 1'b1;
         w_addend     = BCD_PELLET;
      end else if (w_req_dot) begin
         w_svc_dot = 1'b1;
         w_addend  = BCD_DOT;
      end
      w_score_nxt      = (w_req_ghost || w_req_pellet || w_req_dot) ? w_sum : r_score;
      w_pend_combo_nxt = (w_ghost && !r_pend_ghost) ? r_combo : r_pend_combo;

      w_dots_nxt = r_dots;
      if (w_dot && (r_dots != '0)) begin
         w_dots_nxt = r_dots - DOTS_W'(1);
      end

      w_lives_nxt = r_lives;
      if (w_death && (r_lives != '0)) begin
         w_lives_nxt = r_lives - LIVES_W'(1);
      end

      // Pellet reload beats a coincident frame_tick; a death kills the timer.
      w_fright_nxt = r_fright_cnt;
      if (w_death) begin
         w_fright_nxt = '0;
      end else if (w_pellet) begin
         w_fright_nxt = FRIGHT_LOAD;
      end else if (frame_tick && (r_fright_cnt != '0)) begin
         w_fright_nxt = r_fright_cnt - FR_W'(1);
      end

      // The ghost being eaten this cycle was priced with the old combo.
      w_combo_nxt = r_combo;
      if (w_ghost && (r_combo != 2'd3)) begin
         w_combo_nxt = r_combo + 2'd1;
      end
      if (w_pellet || (w_fright_nxt == '0)) begin
         w_combo_nxt = 2'd0;
      end

      w_death_nxt = r_death_cnt;
      if (w_death) begin
         w_death_nxt = '0;
      end else if ((r_state == ST_DYING) && frame_tick) begin
         w_death_nxt = r_death_cnt + DT_W'(1);
      end

      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_GAMEOVER: if (start) w_state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (w_death)             w_state_nxt = ST_DYING;
            else if (r_dots == '0)   w_state_nxt = ST_WIN;
         end
         ST_DYING: begin
            if (frame_tick && (r_death_cnt == DEATH_LAST)) begin
               w_state_nxt = (r_lives == '0) ? ST_GAMEOVER : ST_PLAY;
            end
         end
         ST_WIN: begin
            if (start) begin
               w_state_nxt = ST_PLAY;
               w_dots_nxt  = DOTS_LOAD;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_new_game) begin
         w_score_nxt = '0;
         w_lives_nxt = LIVES_LOAD;
         w_dots_nxt  = DOTS_LOAD;
         w_combo_nxt = 2'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= ST_IDLE;
         r_score       <= '0;
         r_lives       <= LIVES_LOAD;
         r_dots        <= DOTS_LOAD;
         r_fright_cnt  <= '0;
         r_death_cnt   <= '0;
         r_combo       <= 2'd0;
         r_pend_dot    <= 1'b0;
         r_pend_pellet <= 1'b0;
         r_pend_ghost  <= 1'b0;
         r_pend_combo  <= 2'd0;
         r_frightened  <= 1'b0;
         r_restart     <= 1'b0;
         r_life_down   <= 1'b0;
         r_win         <= 1'b0;
         r_lose        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_score       <= w_score_nxt;
         r_lives       <= w_lives_nxt;
         r_dots        <= w_dots_nxt;
         r_fright_cnt  <= w_fright_nxt;
         r_death_cnt   <= w_death_nxt;
         r_combo       <= w_combo_nxt;
         r_pend_dot    <= !w_new_game && w_req_dot    && !w_svc_dot;
         r_pend_pellet <= !w_new_game && w_req_pellet && !w_svc_pellet;
         r_pend_ghost  <= !w_new_game && w_req_ghost  && !w_svc_ghost;
         r_pend_combo  <= w_pend_combo_nxt;
         r_frightened  <= (w_fright_nxt != '0);
         r_restart     <= (w_state_nxt == ST_PLAY) && (r_state != ST_PLAY);
         r_life_down   <= w_death;
         r_win         <= (w_state_nxt == ST_WIN);
         r_lose        <= (w_state_nxt == ST_GAMEOVER);
      end
   end

   assign score_bcd  = r_score;
   assign lives      = r_lives;
   assign dots_left  = r_dots;
   assign state      = r_state;
   assign frightened = r_frightened;
   assign restart    = r_restart;
   assign lifeDown   = r_life_down;
   assign win        = r_win;
   assign lose       = r_lose;

endmodule
